nios2_systimer_master: RTL and testbench
========================================

NIOS2_SYSTIMER_MASTER -- requirements
Module: nios2_systimer_master

Interface
REQ-001 clk  input  1  single clock; all logic rising-edge.
REQ-002 reset_n  input  1  asynchronous, active-low reset.
REQ-003 cmd_valid  input  1  command request.
REQ-004 cmd_ready  output  1  high only in IDLE; a command is accepted on cmd_valid && cmd_ready.
REQ-005 cmd_op  input  2  00 LOAD_START, 01 STOP, 10 SNAPSHOT, 11 STATUS_CLEAR.
REQ-006 cmd_period  input  32  timer period for LOAD_START.
REQ-007 cmd_ctrl  input  2  bit0 ITO, bit1 CONT for LOAD_START.
REQ-008 result_valid  output  1  one-cycle pulse at command completion.
REQ-009 result_data  output  32  SNAPSHOT value, or STATUS {30'b0, run, to}; 0 for other ops.
REQ-010 m_address  output  3  timer slave word address.
REQ-011 m_chipselect  output  1  slave select.
REQ-012 m_write_n  output  1  active-low write.
REQ-013 m_writedata  output  16  write data.
REQ-014 m_readdata  input  16  slave read data, valid the cycle after the address is presented (fixed latency 1, no waitrequest).
REQ-015 irq  input  1  timer interrupt level.
REQ-016 irq_rise  output  1  one-cycle pulse, registered, the cycle after irq goes 0->1.
REQ-017 irq_count  output  8  saturating count of irq rising edges.

Function
REQ-018 All bus outputs are registered; idle bus: chipselect 0, write_n 1, address 0, writedata 0.
REQ-019 Command fields are captured at acceptance; later input changes have no effect until the next acceptance.
REQ-020 FSM states: IDLE, WR_PL, WR_PH, WR_CTRL, SNAP_WR, RD_L, RD_H, CAP_H, ST_RD, ST_CAP, ST_CLR, DONE.
REQ-021 LOAD_START: WR_PL (addr 2, period[15:0]) -> WR_PH (addr 3, period[31:16]) -> WR_CTRL (addr 1, {STOP=0, START=1, CONT, ITO}) -> DONE.
REQ-022 STOP: WR_CTRL (addr 1, data 16'h0008) -> DONE.
REQ-023 SNAPSHOT: SNAP_WR (write addr 4, data 0) -> RD_L (read addr 4) -> RD_H (read addr 5; capture m_readdata as low half) -> CAP_H (bus idle; capture m_readdata as high half) -> DONE.
REQ-024 STATUS_CLEAR: ST_RD (read addr 0) -> ST_CAP (bus idle; capture m_readdata[1:0]) -> ST_CLR (write addr 0, data 0) -> DONE; irq_count is cleared in ST_CLR.
REQ-025 One bus access per state, each lasting exactly one cycle; reads drive chipselect 1, write_n 1.
REQ-026 DONE: result_valid = 1 for one cycle, result_data updated in the same cycle; DONE -> IDLE unconditionally.
REQ-027 Latency from acceptance cycle to result_valid: LOAD_START 4, STOP 2, SNAPSHOT 5, STATUS_CLEAR 4 cycles.
REQ-028 result_data holds its value until the next DONE.
REQ-029 irq_count saturates at 255.
REQ-030 An irq rise coinciding with ST_CLR: clear wins, and the count becomes 0.
REQ-031 irq edge detection runs in every state, independent of the FSM.

Reset
REQ-032 On reset_n low, asynchronously: state IDLE, cmd_ready 1 after release, result_valid 0, result_data 0, irq_rise 0, irq_count 0, irq history 0, bus idle per REQ-018.
REQ-033 Reset during any command abandons it; no result_valid is produced and no further bus access is issued.

Structure
REQ-034 Shared package nios2_systimer_pkg holds register address constants (0 status, 1 control, 2 period_l, 3 period_h, 4 snap_l, 5 snap_h), control bit positions (ITO 0, CONT 1, START 2, STOP 3), op encodings and the FSM state type.
REQ-035 One sub-module, nios2_systimer_irq_mon, contains irq edge detection and the saturating counter with a clear input.

Verification
REQ-036 LOAD_START, period 32'h0008_3D5F, ctrl 2'b11 -> writes addr2=3D5F, addr3=0008, addr1=0007 on consecutive cycles; result_valid 4 cycles after acceptance; result_data 0.
REQ-037 SNAPSHOT against a slave model whose snapshot is 32'h1234_5678 -> write addr4, reads addr4 then addr5; result_data 32'h1234_5678 5 cycles after acceptance.
REQ-038 Three irq pulses, then STATUS_CLEAR with slave status 2'b11 -> irq_count 3 then 0; result_data 32'h3; write addr0=0 observed.
REQ-039 300 irq rising edges -> irq_count 255; irq_rise is high for exactly 300 cycles in total.
REQ-040 reset_n asserted in RD_H of SNAPSHOT -> bus idle immediately, no result_valid, cmd_ready 1 on the first cycle after release.
REQ-041 cmd_valid held high with changing cmd_op while busy -> only the first op executes, and the next op is accepted only in IDLE after DONE.

Source files
------------

// File: rtl/nios2_systimer_pkg.sv
// Register map, control bits, op codes and FSM states for the system timer master.
// Pure declarations: no latency or backpressure of its own.
package nios2_systimer_pkg;

    localparam logic [2:0] ADDR_STATUS   = 3'd0;
    localparam logic [2:0] ADDR_CONTROL  = 3'd1;
    localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
    localparam logic [2:0] ADDR_PERIOD_H = 3'd3;
    localparam logic [2:0] ADDR_SNAP_L   = 3'd4;
    localparam logic [2:0] ADDR_SNAP_H   = 3'd5;

    localparam int CTRL_ITO   = 0;
    localparam int CTRL_CONT  = 1;
    localparam int CTRL_START = 2;
    localparam int CTRL_STOP  = 3;

    typedef enum logic [1:0] {
        OP_LOAD_START   = 2'b00,
        OP_STOP         = 2'b01,
        OP_SNAPSHOT     = 2'b10,
        OP_STATUS_CLEAR = 2'b11
    } op_e;

    typedef enum logic [3:0] {
        S_IDLE, S_WR_PL, S_WR_PH, S_WR_CTRL, S_SNAP_WR, S_RD_L,
        S_RD_H, S_CAP_H, S_ST_RD, S_ST_CAP, S_ST_CLR, S_DONE
    } state_e;

    typedef struct packed {
        logic        cs;
        logic        write_n;
        logic [2:0]  addr;
        logic [15:0] wdata;
    } bus_t;

    localparam bus_t BUS_IDLE = '{cs: 1'b0, write_n: 1'b1, addr: 3'd0, wdata: 16'd0};

    function automatic bus_t bus_wr(input logic [2:0] addr, input logic [15:0] data);
        return '{cs: 1'b1, write_n: 1'b0, addr: addr, wdata: data};
    endfunction

    function automatic bus_t bus_rd(input logic [2:0] addr);
        return '{cs: 1'b1, write_n: 1'b1, addr: addr, wdata: 16'd0};
    endfunction

    function automatic logic [15:0] ctrl_word(input logic [1:0] ctrl);
        logic [15:0] w;
        w = 16'd0;
        w[CTRL_ITO]   = ctrl[0];
        w[CTRL_CONT]  = ctrl[1];
        w[CTRL_START] = 1'b1;
        w[CTRL_STOP]  = 1'b0;
        return w;
    endfunction

endpackage

// File: rtl/nios2_systimer_irq_mon.sv
// irq rising-edge pulse (1 cycle after the edge) and saturating edge counter with clear.
// Always ready; clear takes priority over a coincident edge.
module nios2_systimer_irq_mon (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       irq,
    input  logic       clr,
    output logic       irq_rise,
    output logic [7:0] irq_count
);

    logic irq_q;
    logic rise;

    assign rise = irq & ~irq_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_q     <= 1'b0;
            irq_rise  <= 1'b0;
            irq_count <= 8'd0;
        end else begin
            irq_q    <= irq;
            irq_rise <= rise;
            if (clr)
                irq_count <= 8'd0;
            else if (rise && irq_count != 8'hFF)
                irq_count <= irq_count + 8'd1;
        end
    end

endmodule

// File: rtl/nios2_systimer_master.sv
// Command-driven bus master for the timer slave; results 2-5 cycles after acceptance.
// cmd_ready only in IDLE, so one command is in flight at a time.
module nios2_systimer_master
    import nios2_systimer_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] cmd_period,
    input  logic [1:0]  cmd_ctrl,
    output logic        result_valid,
    output logic [31:0] result_data,
    output logic [2:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [15:0] m_writedata,
    input  logic [15:0] m_readdata,
    input  logic        irq,
    output logic        irq_rise,
    output logic [7:0]  irq_count
);

    state_e      state;
    bus_t        bus;
    logic [15:0] period_hi_q;
    logic [1:0]  ctrl_q;
    logic [15:0] snap_lo;
    logic [1:0]  status_q;

    assign m_chipselect = bus.cs;
    assign m_write_n    = bus.write_n;
    assign m_address    = bus.addr;
    assign m_writedata  = bus.wdata;

    // Bus fields are loaded on the edge entering each state, so every access
    // is seen on the bus for exactly the cycle the FSM sits in that state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            bus          <= BUS_IDLE;
            cmd_ready    <= 1'b1;
            result_valid <= 1'b0;
            result_data  <= 32'd0;
            period_hi_q  <= 16'd0;
            ctrl_q       <= 2'd0;
            snap_lo      <= 16'd0;
            status_q     <= 2'd0;
        end else begin
            bus          <= BUS_IDLE;
            result_valid <= 1'b0;
            cmd_ready    <= 1'b0;
            case (state)
                S_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready   <= 1'b0;
                        period_hi_q <= cmd_period[31:16];
                        ctrl_q      <= cmd_ctrl;
                        case (op_e'(cmd_op))
                            OP_LOAD_START: begin
                                state <= S_WR_PL;
                                bus   <= bus_wr(ADDR_PERIOD_L, cmd_period[15:0]);
                            end
                            OP_STOP: begin
                                state <= S_WR_CTRL;
                                bus   <= bus_wr(ADDR_CONTROL, 16'h0008);
                            end
                            OP_SNAPSHOT: begin
                                state <= S_SNAP_WR;
                                bus   <= bus_wr(ADDR_SNAP_L, 16'h0000);
                            end
                            default: begin
                                state <= S_ST_RD;
                                bus   <= bus_rd(ADDR_STATUS);
                            end
                        endcase
                    end
                end
                S_WR_PL: begin
                    state <= S_WR_PH;
                    bus   <= bus_wr(ADDR_PERIOD_H, period_hi_q);
                end
                S_WR_PH: begin
                    state <= S_WR_CTRL;
                    bus   <= bus_wr(ADDR_CONTROL, ctrl_word(ctrl_q));
                end
                S_WR_CTRL: begin
                    state        <= S_DONE;
                    result_valid <= 1'b1;
                    result_data  <= 32'd0;
                end
                S_SNAP_WR: begin
                    state <= S_RD_L;
                    bus   <= bus_rd(ADDR_SNAP_L);
                end
                S_RD_L: begin
                    state <= S_RD_H;
                    bus   <= bus_rd(ADDR_SNAP_H);
                end
                S_RD_H: begin
                    state   <= S_CAP_H;
                    snap_lo <= m_readdata;
                end
                S_CAP_H: begin
                    state        <= S_DONE;
                    result_valid <= 1'b1;
                    result_data  <= {m_readdata, snap_lo};
                end
                S_ST_RD: begin
                    state <= S_ST_CAP;
                end
                S_ST_CAP: begin
                    state    <= S_ST_CLR;
                    status_q <= m_readdata[1:0];
                    bus      <= bus_wr(ADDR_STATUS, 16'h0000);
                end
                S_ST_CLR: begin
                    state        <= S_DONE;
                    result_valid <= 1'b1;
                    result_data  <= {30'd0, status_q};
                end
                S_DONE: begin
                    state     <= S_IDLE;
                    cmd_ready <= 1'b1;
                end
                default: begin
                    state     <= S_IDLE;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

    nios2_systimer_irq_mon u_irq_mon (
        .clk       (clk),
        .reset_n   (reset_n),
        .irq       (irq),
        .clr       (state == S_ST_CLR),
        .irq_rise  (irq_rise),
        .irq_count (irq_count)
    );

endmodule

// File: tb/tb_nios2_systimer_master.sv
// Directed bench for nios2_systimer_master: command table plus irq/reset/busy sequences.
module tb_nios2_systimer_master;
    import nios2_systimer_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_period;
    logic [1:0]  cmd_ctrl;
    logic        result_valid;
    logic [31:0] result_data;
    logic [2:0]  m_address;
    logic        m_chipselect;
    logic        m_write_n;
    logic [15:0] m_writedata;
    logic [15:0] m_readdata = 16'h0;
    logic        irq;
    logic        irq_rise;
    logic [7:0]  irq_count;

    always #5 clk = ~clk;

    nios2_systimer_master dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_period   (cmd_period),
        .cmd_ctrl     (cmd_ctrl),
        .result_valid (result_valid),
        .result_data  (result_data),
        .m_address    (m_address),
        .m_chipselect (m_chipselect),
        .m_write_n    (m_write_n),
        .m_writedata  (m_writedata),
        .m_readdata   (m_readdata),
        .irq          (irq),
        .irq_rise     (irq_rise),
        .irq_count    (irq_count)
    );

    // Slave model: read data returned one cycle after the address; junk otherwise.
    logic [15:0] sl_status;
    always @(posedge clk) begin
        if (m_chipselect && m_write_n) begin
            case (m_address)
                3'd0:    m_readdata <= sl_status;
                3'd4:    m_readdata <= 16'h5678;
                3'd5:    m_readdata <= 16'h1234;
                default: m_readdata <= 16'hBAD0;
            endcase
        end else begin
            m_readdata <= 16'hBAD0;
        end
    end

    typedef struct {
        int          cyc;
        logic        w;
        logic [2:0]  a;
        logic [15:0] d;
    } acc_t;

    int   cyc = 0;
    acc_t log_q[$];
    int   acc_cyc = 0, acc_count = 0;
    int   rv_cyc = 0, rv_count = 0;
    logic [31:0] rv_data = 32'h0;
    int   rise_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        acc_t e;
        if (m_chipselect) begin
            e.cyc = cyc; e.w = !m_write_n; e.a = m_address; e.d = m_writedata;
            log_q.push_back(e);
        end
        if (cmd_valid && cmd_ready) begin
            acc_cyc   = cyc;
            acc_count = acc_count + 1;
        end
        if (result_valid) begin
            rv_cyc   = cyc;
            rv_data  = result_data;
            rv_count = rv_count + 1;
        end
        if (irq_rise) rise_cnt = rise_cnt + 1;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Access record: {offset from acceptance, write, address, data}.
    function automatic logic [23:0] acc(input logic [3:0] off, input logic w,
                                        input logic [2:0] a, input logic [15:0] d);
        return {off, w, a, d};
    endfunction

    typedef struct {
        logic [1:0]  op;
        logic [31:0] period;
        logic [1:0]  ctrl;
        logic [15:0] st;
        int          lat;
        logic [31:0] res;
        int          n;
        logic [23:0] accs [4];
    } vec_t;

    vec_t vecs [8];

    task automatic wait_result(input int base_rv);
        int k;
        k = 0;
        while (rv_count == base_rv && k < 20) begin
            step();
            k++;
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int base_log, base_acc, base_rv, idx;
        logic [23:0] got;
        sl_status  = v.st;
        base_log   = log_q.size();
        base_acc   = acc_count;
        base_rv    = rv_count;
        cmd_op     = v.op;
        cmd_period = v.period;
        cmd_ctrl   = v.ctrl;
        cmd_valid  = 1'b1;
        step();
        cmd_valid  = 1'b0;
        cmd_op     = ~v.op;
        cmd_period = ~v.period;
        cmd_ctrl   = ~v.ctrl;
        wait_result(base_rv);
        chk({tag, ":results"}, rv_count - base_rv, 1);
        chk({tag, ":accepts"}, acc_count - base_acc, 1);
        chk({tag, ":latency"}, rv_cyc - acc_cyc, v.lat);
        chk({tag, ":result"}, rv_data, v.res);
        chk({tag, ":hold"}, result_data, v.res);
        chk({tag, ":nacc"}, log_q.size() - base_log, v.n);
        for (int j = 0; j < v.n; j++) begin
            idx = base_log + j;
            if (idx < log_q.size())
                got = acc(4'(log_q[idx].cyc - acc_cyc), log_q[idx].w, log_q[idx].a, log_q[idx].d);
            else
                got = 24'hFFFFFF;
            chk($sformatf("%s:acc%0d", tag, j), got, v.accs[j]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int base_rv, base_acc, base_log, base_rise, k;

        reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_period = 32'h0;
        cmd_ctrl = 2'b00; irq = 1'b0; sl_status = 16'h0;

        vecs[0] = '{2'b00, 32'h0008_3D5F, 2'b11, 16'h0, 4, 32'h0, 3,
                    '{acc(1, 1, 3'd2, 16'h3D5F), acc(2, 1, 3'd3, 16'h0008), acc(3, 1, 3'd1, 16'h0007), 24'h0}};
        vecs[1] = '{2'b01, 32'hDEAD_BEEF, 2'b11, 16'h0, 2, 32'h0, 1,
                    '{acc(1, 1, 3'd1, 16'h0008), 24'h0, 24'h0, 24'h0}};
        vecs[2] = '{2'b10, 32'h0, 2'b00, 16'h0, 5, 32'h1234_5678, 3,
                    '{acc(1, 1, 3'd4, 16'h0000), acc(2, 0, 3'd4, 16'h0000), acc(3, 0, 3'd5, 16'h0000), 24'h0}};
        vecs[3] = '{2'b11, 32'h0, 2'b00, 16'h0003, 4, 32'h3, 2,
                    '{acc(1, 0, 3'd0, 16'h0000), acc(3, 1, 3'd0, 16'h0000), 24'h0, 24'h0}};
        vecs[4] = '{2'b00, 32'hFFFF_0001, 2'b00, 16'h0, 4, 32'h0, 3,
                    '{acc(1, 1, 3'd2, 16'h0001), acc(2, 1, 3'd3, 16'hFFFF), acc(3, 1, 3'd1, 16'h0004), 24'h0}};
        vecs[5] = '{2'b00, 32'hA5A5_5A5A, 2'b10, 16'h0, 4, 32'h0, 3,
                    '{acc(1, 1, 3'd2, 16'h5A5A), acc(2, 1, 3'd3, 16'hA5A5), acc(3, 1, 3'd1, 16'h0006), 24'h0}};
        vecs[6] = '{2'b11, 32'h0, 2'b00, 16'hFFFE, 4, 32'h2, 2,
                    '{acc(1, 0, 3'd0, 16'h0000), acc(3, 1, 3'd0, 16'h0000), 24'h0, 24'h0}};
        vecs[7] = '{2'b00, 32'h1234_0000, 2'b01, 16'h0, 4, 32'h0, 3,
                    '{acc(1, 1, 3'd2, 16'h0000), acc(2, 1, 3'd3, 16'h1234), acc(3, 1, 3'd1, 16'h0005), 24'h0}};

        repeat (3) step();
        chk("inrst_cs", m_chipselect, 0);
        chk("inrst_rv", result_valid, 0);
        reset_n = 1'b1;
        step();
        chk("rst_ready", cmd_ready, 1);
        chk("rst_rv", result_valid, 0);
        chk("rst_rdata", result_data, 0);
        chk("rst_cnt", irq_count, 0);
        chk("rst_rise", irq_rise, 0);
        chk("rst_wn", m_write_n, 1);
        chk("rst_addr", m_address, 0);
        chk("rst_wdata", m_writedata, 0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Three irq pulses, then STATUS_CLEAR wipes the count.
        repeat (3) begin
            irq = 1'b1; step(); step();
            irq = 1'b0; step(); step();
        end
        chk("irq3_cnt", irq_count, 3);
        run_vec(vecs[3], "stclr");
        chk("irq3_cleared", irq_count, 0);

        // irq edge landing in ST_CLR: clear wins.
        irq = 1'b1; step(); irq = 1'b0; step(); step();
        chk("pre_clr_cnt", irq_count, 1);
        sl_status = 16'h0;
        cmd_op = 2'b11; cmd_valid = 1'b1; step(); cmd_valid = 1'b0;
        step();
        step();
        irq = 1'b1; step();
        chk("coin_rise", irq_rise, 1);
        chk("coin_cnt", irq_count, 0);
        chk("coin_rv", result_valid, 1);
        irq = 1'b0; step(); step();
        chk("coin_cnt_after", irq_count, 0);

        // 300 edges saturate the counter.
        base_rise = rise_cnt;
        for (int i = 0; i < 300; i++) begin
            irq = 1'b1; step();
            irq = 1'b0; step();
            if (i == 254) chk("sat_at_255", irq_count, 255);
        end
        step();
        chk("sat_final", irq_count, 255);
        chk("rise_cycles", rise_cnt - base_rise, 300);

        // Reset asserted while SNAPSHOT sits in RD_H.
        base_rv = rv_count;
        cmd_op = 2'b10; cmd_valid = 1'b1; step(); cmd_valid = 1'b0;
        step();
        step();
        chk("rdh_addr", m_address, 5);
        chk("rdh_cs", m_chipselect, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_cs", m_chipselect, 0);
        chk("arst_wn", m_write_n, 1);
        chk("arst_addr", m_address, 0);
        step(); step();
        reset_n = 1'b1;
        base_log = log_q.size();
        step();
        chk("rel_ready", cmd_ready, 1);
        repeat (8) step();
        chk("rel_no_result", rv_count - base_rv, 0);
        chk("rel_no_access", log_q.size() - base_log, 0);

        // cmd_valid held high with ops changing while busy.
        base_rv = rv_count; base_acc = acc_count; base_log = log_q.size();
        cmd_op = 2'b10; cmd_period = 32'h0; cmd_ctrl = 2'b00; cmd_valid = 1'b1;
        step();
        k = 0;
        while (rv_count == base_rv && k < 20) begin
            cmd_op = 2'(k);
            cmd_period = 32'h0101_0101 * k;
            if (k == 1) chk("busy_ready", cmd_ready, 0);
            step();
            k++;
        end
        chk("hold_results", rv_count - base_rv, 1);
        chk("hold_accepts", acc_count - base_acc, 1);
        chk("hold_snap", rv_data, 32'h1234_5678);
        chk("hold_nacc", log_q.size() - base_log, 3);
        chk("hold_idle_ready", cmd_ready, 1);
        cmd_op = 2'b01;
        base_rv = rv_count;
        step();
        cmd_valid = 1'b0;
        wait_result(base_rv);
        chk("next_accepts", acc_count - base_acc, 2);
        chk("next_latency", rv_cyc - acc_cyc, 2);
        chk("next_nacc", log_q.size() - base_log, 4);
        if (log_q.size() > 0)
            chk("next_stop_wr", {log_q[log_q.size()-1].w, log_q[log_q.size()-1].a, log_q[log_q.size()-1].d},
                {1'b1, 3'd1, 16'h0008});
        else
            chk("next_stop_wr", 32'hFFFF_FFFF, {1'b1, 3'd1, 16'h0008});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
